serial_subtractor: RTL and testbench

Bit-serial N-bit subtractor that computes the difference and borrow of two operands, one bit per clock, LSB first. It is the inverse-direction companion to the team's combinational ripple-carry adders: the adder produces A+B+Cin, this block produces A−B−Bin. It uses a single full-subtractor cell and a registered borrow instead of N parallel cells. It sits behind a start/done handshake so a controller or test harness can issue operations and check results against the adder datapath, where A = Diff + B + Bin.

---
 rtl/serial_sub_pkg.sv | 12 +
 rtl/full_subtractor.sv | 13 +
 rtl/serial_subtractor.sv | 115 +++++++++++
 tb/tb_serial_subtractor.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package serial_sub_pkg;

  localparam int DEFAULT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/full_subtractor.sv
// Single-bit full subtractor: D = X - Y - Bi, Bo is the borrow out of this bit.
module full_subtractor (
  input  logic X,
  input  logic Y,
  input  logic Bi,
  output logic D,
  output logic Bo
);

  assign D  = X ^ Y ^ Bi;
  assign Bo = (~X & Y) | (~(X ^ Y) & Bi);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial A - B - Bin, LSB first, one full-subtractor cell and a registered borrow.
// Start/Done handshake; back-to-back operations are accepted in the DONE cycle.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int W = DEFAULT_W
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         Start,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  logic         Bin,
  output logic         Busy,
  output logic         Done,
  output logic [W-1:0] Diff,
  output logic         Bout
);

  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  state_t state_reg, state_next;

  logic [W-1:0]  sa_reg;
  logic [W-1:0]  sb_reg;
  logic [W-2:0]  res_reg;   // bit 0 of the result is never needed again once shifted
  logic          brw_reg;
  logic [CW-1:0] cnt_reg;

  logic          load;
  logic          shift;
  logic          finish;
  logic          d_bit;
  logic          brw_next;
  logic [W-1:0]  result_next;

  full_subtractor u_cell (
    .X  (sa_reg[0]),
    .Y  (sb_reg[0]),
    .Bi (brw_reg),
    .D  (d_bit),
    .Bo (brw_next)
  );

  assign result_next = {d_bit, res_reg};

  always_ff @(posedge CLK) begin
    if (RST) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    load       = 1'b0;
    shift      = 1'b0;
    finish     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (Start) begin
          load       = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        shift = 1'b1;
        if (cnt_reg == LAST) begin
          finish     = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        if (Start) begin
          load       = 1'b1;
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      sa_reg  <= '0;
      sb_reg  <= '0;
      res_reg <= '0;
      brw_reg <= 1'b0;
      cnt_reg <= '0;
      Diff    <= '0;
      Bout    <= 1'b0;
    end else if (load) begin
      sa_reg  <= A;
      sb_reg  <= B;
      brw_reg <= Bin;
      cnt_reg <= '0;
    end else if (shift) begin
      sa_reg  <= sa_reg >> 1;
      sb_reg  <= sb_reg >> 1;
      brw_reg <= brw_next;
      res_reg <= result_next[W-1:1];
      // Counter parks at W-1 rather than wrapping.
      if (!finish) cnt_reg <= cnt_reg + CW'(1);
      if (finish) begin
        Diff <= result_next;
        Bout <= brw_next;
      end
    end
  end

  assign Busy = (state_reg == RUN);
  assign Done = (state_reg == DONE);

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor (W=4): stimulus pushes expected results,
// a negedge monitor pops and checks value and latency whenever Done pulses.
module tb_serial_subtractor;

  localparam int W = 4;

  logic         CLK;
  logic         RST;
  logic         Start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         Bin;
  logic         Busy;
  logic         Done;
  logic [W-1:0] Diff;
  logic         Bout;

  typedef struct {
    int diff;
    int bout;
    int acc;
    string name;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  serial_subtractor #(.W(W)) dut (
    .CLK   (CLK),
    .RST   (RST),
    .Start (Start),
    .A     (A),
    .B     (B),
    .Bin   (Bin),
    .Busy  (Busy),
    .Done  (Done),
    .Diff  (Diff),
    .Bout  (Bout)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every Done pulse must match the oldest outstanding expectation.
  always @(negedge CLK) begin
    if (Done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL stray_done: got Done=1 with Diff=%0d Bout=%0d, expected no Done (cycle %0d)",
                 Diff, Bout, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        $display("txn %s: Diff=%0d Bout=%0d (exp %0d/%0d) latency=%0d",
                 mon_e.name, Diff, Bout, mon_e.diff, mon_e.bout, cyc - mon_e.acc);
        check({mon_e.name, "_diff"}, int'(Diff), mon_e.diff);
        check({mon_e.name, "_bout"}, int'(Bout), mon_e.bout);
        check({mon_e.name, "_latency"}, cyc - mon_e.acc, W);
        check({mon_e.name, "_busy_at_done"}, int'(Busy), 0);
      end
    end
  end

  // Called at a negedge: request an op, then scramble operands after acceptance.
  task automatic issue(input string name, input int a, input int b, input int bi,
                       input int ed, input int eb);
    exp_t e;
    Start = 1'b1;
    A     = W'(a);
    B     = W'(b);
    Bin   = bi[0];
    e.diff = ed;
    e.bout = eb;
    e.acc  = cyc + 1;
    e.name = name;
    exp_q.push_back(e);
    @(negedge CLK);
    Start = 1'b0;
    A     = ~A;
    B     = B + 4'd5;
    Bin   = ~Bin;
    check({name, "_busy"}, int'(Busy), 1);
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge CLK);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL timeout: got %0d results outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
    @(negedge CLK);
  endtask

  initial begin
    RST   = 1'b1;
    Start = 1'b0;
    A     = '0;
    B     = '0;
    Bin   = 1'b0;
    repeat (3) @(negedge CLK);
    check("rst_busy", int'(Busy), 0);
    check("rst_done", int'(Done), 0);
    check("rst_diff", int'(Diff), 0);
    check("rst_bout", int'(Bout), 0);
    RST = 1'b0;
    @(negedge CLK);

    issue("9m3", 9, 3, 0, 6, 0);
    wait_drain(20);
    repeat (3) @(negedge CLK);
    check("hold_diff", int'(Diff), 6);
    check("idle_busy", int'(Busy), 0);

    issue("3m9", 3, 9, 0, 10, 1);
    wait_drain(20);
    issue("0m0b1", 0, 0, 1, 15, 1);
    wait_drain(20);
    issue("15m15", 15, 15, 0, 0, 0);
    wait_drain(20);
    issue("8m1b1", 8, 1, 1, 6, 0);
    wait_drain(20);

    // Start held high: only the first op and the one sampled in DONE run.
    begin
      int ta[7] = '{7, 3, 12, 9, 6, 1, 14};
      int tb[7] = '{2, 3, 1, 9, 6, 2, 0};
      for (int i = 0; i < 7; i++) begin
        exp_t e;
        Start = 1'b1;
        A     = W'(ta[i]);
        B     = W'(tb[i]);
        Bin   = 1'b0;
        if (i == 0 || i == 5) begin
          e.diff = (i == 0) ? 5 : 15;
          e.bout = (i == 0) ? 0 : 1;
          e.acc  = cyc + 1;
          e.name = (i == 0) ? "7m2" : "1m2_b2b";
          exp_q.push_back(e);
        end
        @(negedge CLK);
      end
      Start = 1'b0;
    end
    wait_drain(20);

    // Reset at RUN count 2, with a Start that must be ignored on the reset edge.
    Start = 1'b1;
    A     = 4'd6;
    B     = 4'd1;
    @(negedge CLK);
    Start = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    RST   = 1'b1;
    Start = 1'b1;
    A     = 4'd3;
    B     = 4'd1;
    @(negedge CLK);
    check("midrst_busy", int'(Busy), 0);
    check("midrst_done", int'(Done), 0);
    check("midrst_diff", int'(Diff), 0);
    check("midrst_bout", int'(Bout), 0);
    RST   = 1'b0;
    Start = 1'b0;
    repeat (8) @(negedge CLK);
    check("post_rst_busy", int'(Busy), 0);

    issue("5m5", 5, 5, 0, 0, 0);
    wait_drain(20);
    check("queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
